pulse_stretcher: RTL and testbench

- Output-side counterpart of input debouncing. Turns short internal events into human-visible fixed-length pulses for LEDs and buzzers on the shell board.
- Guarantees a minimum high time and a minimum low gap, so back-to-back events stay distinguishable.
- Events that arrive while a pulse is in progress are queued in a saturating counter and replayed as separate blinks.
- Sits between core status strobes and board output pins.

---
 rtl/shell_pkg.sv | 16 +
 rtl/edge_detect.sv | 28 ++
 rtl/pulse_stretcher.sv | 141 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/shell_pkg.sv
// Shared types and helpers for the shell-board output blocks.
//   state_e    : pulse stretcher FSM state encoding
//   clog2_max  : ceil(log2(max(a, b))), used to size down-counters
package shell_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic int unsigned clog2_max(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a level signal.
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   sig    : level input
//   rise   : combinational one-cycle pulse on each 0->1 transition of sig
// The history flop resets to 0, so a signal already high when reset is
// released produces one edge on the first cycle.
module edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic sig,
  output logic rise
);

  logic ev_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ev_d <= 1'b0;
    end else begin
      ev_d <= sig;
    end
  end

  assign rise = sig & ~ev_d;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches short event strobes into fixed-length visible pulses with a
// guaranteed minimum low gap; events arriving mid-pulse are queued in a
// saturating counter and replayed as separate pulses.
// Ports:
//   clk           : system clock
//   resetn        : asynchronous active-low reset
//   event_in      : level event source, each rising edge is one event
//   stretched_sig : registered stretched pulse (high while in HOLD)
//   busy          : registered, high while not IDLE
//   pending_cnt   : queued events not yet shown
//   overflow      : sticky, set when an event is dropped at saturation
// Build option: STRETCH_RETRIGGER_EN makes an edge during HOLD restart the
// hold counter (extending the pulse) instead of queueing it.
module pulse_stretcher
  import shell_pkg::*;
#(
  parameter int unsigned hold_depth  = 1048576,
  parameter int unsigned gap_depth   = 262144,
  parameter int unsigned max_pending = 3
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               event_in,
  output logic                               stretched_sig,
  output logic                               busy,
  output logic [$clog2(max_pending + 1)-1:0] pending_cnt,
  output logic                               overflow
);

  localparam int unsigned cnt_width  = clog2_max(hold_depth, gap_depth) + 1;
  localparam int unsigned pend_width = $clog2(max_pending + 1);

  localparam logic [cnt_width-1:0]  hold_last = cnt_width'(hold_depth - 1);
  localparam logic [cnt_width-1:0]  gap_last  = cnt_width'(gap_depth - 1);
  localparam logic [pend_width-1:0] pend_max  = pend_width'(max_pending);

  state_e                state_q, state_d;
  logic [cnt_width-1:0]  cnt_q, cnt_d;
  logic [pend_width-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;
  logic                  rise;
  logic                  push, pop;

  edge_detect u_edge_detect (
    .clk    (clk),
    .resetn (resetn),
    .sig    (event_in),
    .rise   (rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == hold_last) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_width'(1);
        end
`ifdef STRETCH_RETRIGGER_EN
        // Retrigger wins over the end-of-hold transition.
        if (rise) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
`else
        push = rise;
`endif
      end
      GAP: begin
        if (cnt_q == gap_last) begin
          cnt_d = '0;
          if (pend_q != '0) begin
            state_d = HOLD;
            pop     = 1'b1;
            push    = rise;
          end else if (rise) begin
            // Fresh edge on the last gap cycle starts the next pulse directly.
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + cnt_width'(1);
          push  = rise;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating queue; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (push && !pop) begin
      if (pend_q == pend_max) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + pend_width'(1);
      end
    end else if (pop && !push) begin
      pend_d = pend_q - pend_width'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pend_q        <= '0;
      ovf_q         <= 1'b0;
      stretched_sig <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      ovf_q         <= ovf_d;
      stretched_sig <= (state_d == HOLD);
      busy          <= (state_d != IDLE);
    end
  end

  assign pending_cnt = pend_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with hold_depth=4, gap_depth=3,
// max_pending=2. Each case resets the DUT, drives event_in per cycle from a
// table and compares all outputs every cycle against hand-derived waveforms.
// Cycle 0 is the first cycle after reset release; an edge in cycle t shows
// on the registered outputs from cycle t+1.
module tb_pulse_stretcher;

  localparam int unsigned Hold = 4;
  localparam int unsigned Gap  = 3;
  localparam int unsigned MaxP = 2;
  localparam int          NCyc = 64;

  logic       clk;
  logic       resetn;
  logic       event_in;
  logic       stretched_sig;
  logic       busy;
  logic [1:0] pending_cnt;
  logic       overflow;

  int n_tests;
  int n_fail;

  bit ev_v  [NCyc];
  bit exp_s [NCyc];
  bit exp_b [NCyc];
  bit exp_o [NCyc];
  int exp_p [NCyc];

  pulse_stretcher #(
    .hold_depth  (Hold),
    .gap_depth   (Gap),
    .max_pending (MaxP)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .event_in      (event_in),
    .stretched_sig (stretched_sig),
    .busy          (busy),
    .pending_cnt   (pending_cnt),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_tables();
    for (int i = 0; i < NCyc; i++) begin
      ev_v[i]  = 1'b0;
      exp_s[i] = 1'b0;
      exp_b[i] = 1'b0;
      exp_o[i] = 1'b0;
      exp_p[i] = 0;
    end
  endtask

  task automatic set_ev(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ev_v[i] = 1'b1;
  endtask

  task automatic set_sig(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_s[i] = 1'b1;
  endtask

  task automatic set_busy(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_b[i] = 1'b1;
  endtask

  task automatic set_ovf(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_o[i] = 1'b1;
  endtask

  task automatic set_pend(input int lo, input int hi, input int v);
    for (int i = lo; i <= hi; i++) exp_p[i] = v;
  endtask

  // Reset, then run n cycles from the tables; returns #1 into cycle n.
  task automatic run_case(input string name, input int n);
    event_in = 1'b0;
    resetn   = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int c = 0; c < n; c++) begin
      event_in = ev_v[c];
      @(negedge clk);
      check($sformatf("%s sig c%0d", name, c), 32'(stretched_sig), 32'(exp_s[c]));
      check($sformatf("%s busy c%0d", name, c), 32'(busy), 32'(exp_b[c]));
      check($sformatf("%s pend c%0d", name, c), 32'(pending_cnt), exp_p[c]);
      check($sformatf("%s ovf c%0d", name, c), 32'(overflow), 32'(exp_o[c]));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    event_in = 1'b0;
    #3;
    // Reset values before any clock edge
    check("reset sig", 32'(stretched_sig), 0);
    check("reset busy", 32'(busy), 0);
    check("reset pend", 32'(pending_cnt), 0);
    check("reset ovf", 32'(overflow), 0);

    // Single edge
    clear_tables();
    set_ev(10, 10);
    set_sig(11, 14);
    set_busy(11, 17);
    run_case("single", 22);

`ifdef STRETCH_RETRIGGER_EN
    // Edge during HOLD extends the pulse to 7 cycles
    clear_tables();
    set_ev(10, 10);
    set_ev(13, 13);
    set_sig(11, 17);
    set_busy(11, 20);
    run_case("retrig", 26);
`else
    // Two queued events replay as separate pulses
    clear_tables();
    set_ev(10, 10);
    set_ev(12, 12);
    set_ev(14, 14);
    set_sig(11, 14);
    set_sig(18, 21);
    set_sig(25, 28);
    set_busy(11, 31);
    set_pend(13, 14, 1);
    set_pend(15, 17, 2);
    set_pend(18, 24, 1);
    run_case("queue", 36);

    // Fourth event hits a full queue during GAP and is dropped
    clear_tables();
    set_ev(10, 10);
    set_ev(12, 12);
    set_ev(14, 14);
    set_ev(16, 16);
    set_sig(11, 14);
    set_sig(18, 21);
    set_sig(25, 28);
    set_busy(11, 31);
    set_pend(13, 14, 1);
    set_pend(15, 17, 2);
    set_pend(18, 24, 1);
    set_ovf(17, 35);
    run_case("ovf", 36);

    // Held level is a single event
    clear_tables();
    set_ev(10, 40);
    set_sig(11, 14);
    set_busy(11, 17);
    run_case("level", 45);

    // Edge on the last gap cycle with empty queue starts the next pulse directly
    clear_tables();
    set_ev(10, 10);
    set_ev(17, 17);
    set_sig(11, 14);
    set_sig(18, 21);
    set_busy(11, 24);
    run_case("direct", 28);

    // Push and pop in the same cycle keep the count at 1
    clear_tables();
    set_ev(10, 10);
    set_ev(12, 12);
    set_ev(17, 17);
    set_sig(11, 14);
    set_sig(18, 21);
    set_sig(25, 28);
    set_busy(11, 31);
    set_pend(13, 24, 1);
    run_case("pushpop", 36);
`endif

    // Asynchronous reset mid-HOLD with one event pending
    clear_tables();
    set_ev(10, 10);
    set_ev(12, 12);
    set_sig(11, 13);
    set_busy(11, 13);
    set_pend(13, 13, 1);
    run_case("rstmid", 14);
    check("rstmid pre sig", 32'(stretched_sig), 1);
    check("rstmid pre pend", 32'(pending_cnt), 1);
    resetn = 1'b0;
    #1;
    check("rstmid async sig", 32'(stretched_sig), 0);
    check("rstmid async busy", 32'(busy), 0);
    check("rstmid async pend", 32'(pending_cnt), 0);
    check("rstmid async ovf", 32'(overflow), 0);
    @(posedge clk);
    #1;
    event_in = 1'b0;
    resetn   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("rstmid after sig c%0d", c), 32'(stretched_sig), 0);
      check($sformatf("rstmid after busy c%0d", c), 32'(busy), 0);
      check($sformatf("rstmid after pend c%0d", c), 32'(pending_cnt), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
